// File: rtl/sdrc_wr_burst_buf_pkg.sv
// Shared types and defaults for the SDRAM write burst buffer.
// Optional error flags are enabled with the SDRC_WRBUF_ERR_EN macro.
package sdrc_wrbuf_pkg;

    localparam int DEF_APP_DW = 32;
    localparam int DEF_APP_BW = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_AW     = 4;
    localparam int DEF_BLW    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // Byte enables are active low, so all ones means "write nothing".
    localparam logic [DEF_APP_BW-1:0] EN_MASKED = '1;

endpackage

// File: rtl/sdrc_wr_burst_buf_if.sv
// Bus bundle between the producer/controller side and the write burst buffer.
// Optional error flags (SDRC_WRBUF_ERR_EN) are plain ports on the top, not here.
interface sdrc_wr_burst_buf_if #(
    parameter int APP_DW = 32,
    parameter int APP_BW = 4,
    parameter int AW     = 4,
    parameter int BLW    = 5
);
    // Handshake: a word transfers on a rising clk edge where wr_valid && wr_ready;
    // the producer holds wr_data/wr_en_n stable while wr_valid is high and
    // wr_ready is low. burst_req stays high until sampled together with burst_ack.
    logic              wr_valid;
    logic              wr_ready;
    logic [APP_DW-1:0] wr_data;
    logic [APP_BW-1:0] wr_en_n;
    logic [BLW-1:0]    req_len;
    logic              burst_req;
    logic              burst_ack;
    logic [APP_DW-1:0] app_wr_data;
    logic [APP_BW-1:0] app_wr_en_n;
    logic              app_wr_next;
    logic              app_last_wr;
    logic [AW:0]       fifo_count;

    modport slave (
        input  wr_valid, wr_data, wr_en_n, req_len, burst_ack, app_wr_next, app_last_wr,
        output wr_ready, burst_req, app_wr_data, app_wr_en_n, fifo_count
    );

    modport master (
        output wr_valid, wr_data, wr_en_n, req_len, burst_ack, app_wr_next, app_last_wr,
        input  wr_ready, burst_req, app_wr_data, app_wr_en_n, fifo_count
    );

endinterface

// File: rtl/sdrc_wr_burst_buf_fifo.sv
// First-word fall-through FIFO holding write data and byte enables.
// Empty head presents zero data with all enables deasserted (masked write).
module sdrc_wrbuf_fifo #(
    parameter int DW    = 32,
    parameter int BW    = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [BW-1:0] push_en_n,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [BW-1:0] head_en_n,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem    [DEPTH];
    logic [BW-1:0] en_mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    // A pop into an empty FIFO is dropped even if a push lands the same cycle.
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr]    <= push_data;
            en_mem[wptr] <= push_en_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = empty ? '0 : mem[rptr];
    assign head_en_n = empty ? '1 : en_mem[rptr];

endmodule

// File: rtl/sdrc_wr_burst_buf.sv
// Write burst buffer: FIFO plus burst request FSM (IDLE -> REQ -> XFER).
// Define SDRC_WRBUF_ERR_EN to add sticky err_underflow/err_overlen outputs.
module sdrc_wr_burst_buf
    import sdrc_wrbuf_pkg::*;
#(
    parameter int APP_DW = DEF_APP_DW,
    parameter int APP_BW = DEF_APP_BW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = DEF_AW,
    parameter int BLW    = DEF_BLW
) (
    input  logic                clk,
    input  logic                reset_n,
    sdrc_wr_burst_buf_if.slave  bus,
    output state_t              dbg_state,
    output logic [BLW-1:0]      dbg_len
`ifdef SDRC_WRBUF_ERR_EN
    ,
    output logic                err_underflow,
    output logic                err_overlen
`endif
);

    state_t         state_q, state_d;
    logic [BLW-1:0] len_q, len_d;
    logic           full;
    logic           empty;
    logic           pop_req;
    logic           do_pop;
    logic [AW:0]    count;
    logic [BLW:0]   cnt_ext;
    logic [BLW:0]   req_ext;

    assign pop_req = bus.app_wr_next && (state_q == XFER);
    assign do_pop  = pop_req && !empty;

    sdrc_wrbuf_fifo #(
        .DW    (APP_DW),
        .BW    (APP_BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (bus.wr_valid),
        .push_data (bus.wr_data),
        .push_en_n (bus.wr_en_n),
        .pop       (pop_req),
        .head_data (bus.app_wr_data),
        .head_en_n (bus.app_wr_en_n),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.wr_ready   = !full;
    assign bus.fifo_count = count;
    assign bus.burst_req  = (state_q == REQ);
    assign dbg_state      = state_q;
    assign dbg_len        = len_q;

    // Widen both sides so a req_len above DEPTH simply never matches.
    assign cnt_ext = {{(BLW-AW){1'b0}}, count};
    assign req_ext = {1'b0, bus.req_len};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if ((bus.req_len != '0) && (cnt_ext >= req_ext)) begin
                    len_d   = bus.req_len;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.burst_ack) state_d = XFER;
            end
            XFER: begin
                if (bus.app_wr_next && bus.app_last_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SDRC_WRBUF_ERR_EN
    logic [BLW:0] pop_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_cnt_q     <= '0;
            err_underflow <= 1'b0;
            err_overlen   <= 1'b0;
        end else begin
            if ((state_q == REQ) && bus.burst_ack) begin
                pop_cnt_q <= '0;
            end else if (do_pop && (pop_cnt_q != '1)) begin
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            if (bus.app_wr_next && (empty || (state_q != XFER))) err_underflow <= 1'b1;
            // This pop would be number pop_cnt_q+1, beyond the latched length.
            if (do_pop && !bus.app_last_wr && (pop_cnt_q >= {1'b0, len_q})) err_overlen <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/sdrc_wr_burst_buf.md
Name: sdrc_wr_burst_buf

Overview:
- Application-side write data buffer, directly upstream of the SDRAM bus-width converter.
- Accepts 32-bit words and byte enables from the application or bus bridge through a valid/ready handshake.
- Holds the words in a small FIFO and raises a burst request once a full burst is buffered.
- Presents the FIFO head on app_wr_data/app_wr_en_n and pops one word per app_wr_next until app_last_wr ends the burst.

Parameters:
- APP_DW, 32, application data width.
- APP_BW, 4, application byte-enable width (APP_DW/8).
- DEPTH, 16, FIFO depth in words; power of 2, minimum 4.
- AW, 4, log2(DEPTH); pointer width.
- BLW, 5, width of burst length field; must hold DEPTH.

Ports:
- clk  in  1  clock; all flops on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  buffer can accept (not full).
- wr_data  in  APP_DW  producer data.
- wr_en_n  in  APP_BW  producer byte enables, active low.
- req_len  in  BLW  burst length in app words; sampled on IDLE->REQ.
- burst_req  out  1  request to the controller: a burst of req_len words is buffered.
- burst_ack  in  1  controller accepted the request.
- app_wr_data  out  APP_DW  FIFO head data to the converter.
- app_wr_en_n  out  APP_BW  FIFO head byte enables to the converter.
- app_wr_next  in  1  converter consumed the head word.
- app_last_wr  in  1  last word of the current burst; qualified by app_wr_next.
- fifo_count  out  AW+1  words held.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Read/write pointers and count go to 0; state goes to IDLE; latched length goes to 0.
  - burst_req=0, wr_ready=1, app_wr_data=0, app_wr_en_n all 1s, fifo_count=0.
  - Reset mid-burst discards all buffered data; no request is pending on release.
- Push: on wr_valid & wr_ready, memory[wptr] is written and wptr increments, wrapping at DEPTH.
  - The word is visible at the head one cycle later if the FIFO was empty.
- wr_ready = (count != DEPTH), combinational from count. A push attempted when full is not accepted; the producer holds its word.
- Head output: app_wr_data = memory[rptr] and app_wr_en_n = enables[rptr], combinational read (first-word fall-through).
  - When empty: app_wr_data=0, app_wr_en_n all 1s (masked write).
- Pop: on app_wr_next in XFER with count != 0, rptr increments with wrap.
  - app_wr_next when empty: no pop, masked data presented, sticky underflow (see optional feature).
- Simultaneous push and pop: count unchanged; both pointers advance.
  - Push into an empty FIFO in the same cycle as app_wr_next: no pop; the new word becomes the head next cycle.
- fifo_count = count register, 0..DEPTH.
- State machine, registered:
  - IDLE: if req_len != 0 and count >= req_len, latch len <= req_len and go to REQ. burst_req=0.
  - REQ: burst_req=1, held until burst_ack. On burst_ack go to XFER; burst_req drops the next cycle. burst_ack outside REQ is ignored.
  - XFER: pops enabled. app_wr_next & app_last_wr pops the final word and returns to IDLE. app_wr_next without app_last_wr keeps XFER.
  - app_last_wr without app_wr_next is ignored.
  - An early app_last_wr (fewer than len pops) still returns to IDLE; leftover words stay buffered for the next burst.
- burst_req latency: asserted in the cycle after count first reaches req_len while in IDLE.
- Back-to-back bursts: from XFER->IDLE, the next REQ can be entered on the following cycle, giving one idle cycle of burst_req=0.
- req_len > DEPTH never triggers a request (count cannot reach it).

Optional Feature:
- Macro: SDRC_WRBUF_ERR_EN.
- With it:
  - Extra output err_underflow (1 bit): set on app_wr_next when count == 0 or state != XFER.
  - Extra output err_overlen (1 bit): set when a burst's pop count exceeds the latched len without app_last_wr.
  - Both are sticky, cleared only by reset, reset value 0.
  - Pops outside XFER are still suppressed.
- Without it: the ports and the pop-counter register are absent; the same illegal cases are silently ignored.

Decomposition:
- Shared package sdrc_wrbuf_pkg:
  - State encoding typedef: IDLE=2'd0, REQ=2'd1, XFER=2'd2.
  - Constant for the masked enable value (all 1s).
  - Default DEPTH/AW/BLW constants.
- One natural sub-module: sdrc_wrbuf_fifo. Holds storage, pointers, count, full/empty and the combinational head read.
- The burst FSM stays in the top level.

Test Plan:
- Fill and request:
  - Stimulus: req_len=4; push 4 words 0x11111111..0x44444444 with wr_en_n=4'h0.
  - Response: burst_req=1 the cycle after the 4th push, held until burst_ack.
  - Then 4 app_wr_next with app_last_wr on the 4th: heads 0x11111111..0x44444444 in order; state IDLE; fifo_count=0.
- Full:
  - Stimulus: push 16 words with no pops.
  - Response: wr_ready=0 and fifo_count=16. A 17th wr_valid is not accepted. After one pop, wr_ready=1 next cycle.
- Simultaneous push/pop:
  - Stimulus: at count=8 in XFER, assert wr_valid and app_wr_next together for 5 cycles.
  - Response: count stays 8; pointers wrap past 15 without data corruption.
- Early last:
  - Stimulus: req_len=8, 10 words buffered; app_last_wr on the 3rd pop.
  - Response: IDLE with count=7; burst_req re-asserts 1 cycle later only if req_len<=7.
- Empty-head masking:
  - Stimulus: app_wr_next when count=0.
  - Response: app_wr_en_n=4'hF, app_wr_data=0, no pointer move. err_underflow=1 with SDRC_WRBUF_ERR_EN defined.
- Reset mid-burst:
  - Stimulus: reset_n low in XFER with count=5.
  - Response: immediately burst_req=0, fifo_count=0, wr_ready=1, app_wr_en_n=4'hF. After release, no request until a new req_len is buffered.
